// File: rtl/line_setup_pipe.sv
// line_setup_pipe: three-stage Bresenham line setup (capture, delta/steep, swap/output).
// Define LINE_SETUP_ERR_INIT_EN to produce the initial error term (deltax >> 1) on err_out.
module line_setup_pipe #(
    parameter int WIDTH = 10,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] y0,
    input  logic [WIDTH-1:0] y1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x0_out,
    output logic [WIDTH-1:0] x1_out,
    output logic [WIDTH-1:0] y0_out,
    output logic [WIDTH:0]   deltax_out,
    output logic [WIDTH:0]   deltay_out,
    output logic [WIDTH-1:0] ystep_out,
    output logic             steep_out,
    output logic             point_out,
    output logic [WIDTH:0]   err_out,
    output logic [CNT_W-1:0] line_cnt
);

    logic                    s0_valid;
    logic signed [WIDTH-1:0] s0_x0, s0_x1, s0_y0, s0_y1;

    logic                    s1_valid;
    logic signed [WIDTH-1:0] s1_x0, s1_x1, s1_y0, s1_y1;
    logic [WIDTH:0]          s1_adx, s1_ady;
    logic                    s1_steep, s1_point;

    logic                    s1_ready, s2_ready;

    logic signed [WIDTH:0]   dx_c, dy_c;
    logic [WIDTH:0]          adx_c, ady_c;
    logic                    steep_c, point_c;

    logic signed [WIDTH-1:0] sx0_c, sy0_c, sx1_c, sy1_c;
    logic signed [WIDTH-1:0] fx0_c, fy0_c, fx1_c, fy1_c;
    logic                    swap_c;
    logic [WIDTH:0]          ddx_c, ddy_c;

    // A stage may load when empty or when its current contents move on this cycle.
    assign s2_ready = !out_valid || out_ready;
    assign s1_ready = !s1_valid || s2_ready;
    assign in_ready = !s0_valid || s1_ready;

    always_comb begin
        dx_c    = {s0_x1[WIDTH-1], s0_x1} - {s0_x0[WIDTH-1], s0_x0};
        dy_c    = {s0_y1[WIDTH-1], s0_y1} - {s0_y0[WIDTH-1], s0_y0};
        adx_c   = dx_c[WIDTH] ? -dx_c : dx_c;
        ady_c   = dy_c[WIDTH] ? -dy_c : dy_c;
        steep_c = ady_c > adx_c;
        point_c = (s0_x0 == s0_x1) && (s0_y0 == s0_y1);
    end

    // After the steep and endpoint swaps the deltas are just the stage-1 magnitudes.
    always_comb begin
        sx0_c  = s1_steep ? s1_y0 : s1_x0;
        sy0_c  = s1_steep ? s1_x0 : s1_y0;
        sx1_c  = s1_steep ? s1_y1 : s1_x1;
        sy1_c  = s1_steep ? s1_x1 : s1_y1;
        swap_c = sx0_c > sx1_c;
        fx0_c  = swap_c ? sx1_c : sx0_c;
        fy0_c  = swap_c ? sy1_c : sy0_c;
        fx1_c  = swap_c ? sx0_c : sx1_c;
        fy1_c  = swap_c ? sy0_c : sy1_c;
        ddx_c  = s1_steep ? s1_ady : s1_adx;
        ddy_c  = s1_steep ? s1_adx : s1_ady;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s0_valid   <= 1'b0;
            s0_x0      <= '0;
            s0_x1      <= '0;
            s0_y0      <= '0;
            s0_y1      <= '0;
            s1_valid   <= 1'b0;
            s1_x0      <= '0;
            s1_x1      <= '0;
            s1_y0      <= '0;
            s1_y1      <= '0;
            s1_adx     <= '0;
            s1_ady     <= '0;
            s1_steep   <= 1'b0;
            s1_point   <= 1'b0;
            out_valid  <= 1'b0;
            x0_out     <= '0;
            x1_out     <= '0;
            y0_out     <= '0;
            deltax_out <= '0;
            deltay_out <= '0;
            ystep_out  <= '0;
            steep_out  <= 1'b0;
            point_out  <= 1'b0;
`ifdef LINE_SETUP_ERR_INIT_EN
            err_out    <= '0;
`endif
            line_cnt   <= '0;
        end else begin
            if (in_ready) begin
                s0_valid <= in_valid;
                if (in_valid) begin
                    s0_x0 <= x0;
                    s0_x1 <= x1;
                    s0_y0 <= y0;
                    s0_y1 <= y1;
                end
            end

            if (s1_ready) begin
                s1_valid <= s0_valid;
                if (s0_valid) begin
                    s1_x0    <= s0_x0;
                    s1_x1    <= s0_x1;
                    s1_y0    <= s0_y0;
                    s1_y1    <= s0_y1;
                    s1_adx   <= adx_c;
                    s1_ady   <= ady_c;
                    s1_steep <= steep_c;
                    s1_point <= point_c;
                end
            end

            if (s2_ready) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    x0_out     <= fx0_c;
                    x1_out     <= fx1_c;
                    y0_out     <= fy0_c;
                    deltax_out <= ddx_c;
                    deltay_out <= ddy_c;
                    ystep_out  <= (fy0_c < fy1_c) ? WIDTH'(1) : {WIDTH{1'b1}};
                    steep_out  <= s1_steep;
                    point_out  <= s1_point;
`ifdef LINE_SETUP_ERR_INIT_EN
                    err_out    <= {1'b0, ddx_c[WIDTH:1]};
`endif
                end
            end

            if (out_valid && out_ready) begin
                line_cnt <= line_cnt + CNT_W'(1);
            end
        end
    end

`ifndef LINE_SETUP_ERR_INIT_EN
    assign err_out = '0;
`endif

endmodule

// File: tb/tb_line_setup_pipe.sv
// Directed-vector bench for line_setup_pipe (WIDTH=10, CNT_W=4).
// Expected err_out follows LINE_SETUP_ERR_INIT_EN when the bench is built with it.
module tb_line_setup_pipe;

    localparam int W  = 10;
    localparam int CW = 4;
`ifdef LINE_SETUP_ERR_INIT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    logic [W-1:0]  x0, x1, y0, y1;
    logic          out_valid, out_ready;
    logic [W-1:0]  x0_out, x1_out, y0_out, ystep_out;
    logic [W:0]    deltax_out, deltay_out, err_out;
    logic          steep_out, point_out;
    logic [CW-1:0] line_cnt;

    always #5 clk = ~clk;

    line_setup_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1),
        .out_valid(out_valid), .out_ready(out_ready),
        .x0_out(x0_out), .x1_out(x1_out), .y0_out(y0_out),
        .deltax_out(deltax_out), .deltay_out(deltay_out),
        .ystep_out(ystep_out), .steep_out(steep_out), .point_out(point_out),
        .err_out(err_out), .line_cnt(line_cnt)
    );

    typedef struct {
        logic [W-1:0] x0, y0, x1, y1;
        logic [W-1:0] ex0, ex1, ey0;
        logic [W:0]   edx, edy;
        logic [W-1:0] eystep;
        logic         esteep, epoint;
    } vec_t;

    vec_t vecs[10];
    int   q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_out   = 0;
    int   n_seen  = 0;
    logic consumed;
    logic accepted;
    logic prev_stall = 1'b0;
    logic [74:0] snap;

    task automatic set_vec(input int i, input int ax0, input int ay0, input int ax1, input int ay1,
                           input int ex0, input int ex1, input int ey0, input int edx, input int edy,
                           input int eys, input int est, input int ept);
        vecs[i].x0 = W'(ax0);   vecs[i].y0 = W'(ay0);
        vecs[i].x1 = W'(ax1);   vecs[i].y1 = W'(ay1);
        vecs[i].ex0 = W'(ex0);  vecs[i].ex1 = W'(ex1);  vecs[i].ey0 = W'(ey0);
        vecs[i].edx = (W+1)'(edx);
        vecs[i].edy = (W+1)'(edy);
        vecs[i].eystep = W'(eys);
        vecs[i].esteep = est[0];
        vecs[i].epoint = ept[0];
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic check_out();
        int   idx;
        vec_t v;
        logic [W:0] eerr;
        if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL spurious_out: got out_valid=1 required no pending line");
        end else begin
            idx  = q.pop_front();
            v    = vecs[idx];
            eerr = ERR_EN ? (v.edx >> 1) : '0;
            chk($sformatf("v%0d_x0", idx),     32'(x0_out),     32'(v.ex0));
            chk($sformatf("v%0d_x1", idx),     32'(x1_out),     32'(v.ex1));
            chk($sformatf("v%0d_y0", idx),     32'(y0_out),     32'(v.ey0));
            chk($sformatf("v%0d_dx", idx),     32'(deltax_out), 32'(v.edx));
            chk($sformatf("v%0d_dy", idx),     32'(deltay_out), 32'(v.edy));
            chk($sformatf("v%0d_ystep", idx),  32'(ystep_out),  32'(v.eystep));
            chk($sformatf("v%0d_steep", idx),  32'(steep_out),  32'(v.esteep));
            chk($sformatf("v%0d_point", idx),  32'(point_out),  32'(v.epoint));
            chk($sformatf("v%0d_err", idx),    32'(err_out),    32'(eerr));
            n_out++;
        end
    endtask

    // One cycle: drive at the falling edge, sample 1 time unit later.
    task automatic step(input logic iv, input int idx, input logic ordy);
        logic [74:0] cur;
        @(negedge clk);
        in_valid  = iv;
        x0        = vecs[idx].x0;
        y0        = vecs[idx].y0;
        x1        = vecs[idx].x1;
        y1        = vecs[idx].y1;
        out_ready = ordy;
        #1;
        consumed = 1'b0;
        accepted = 1'b0;
        if (out_valid) n_seen++;
        if (out_valid && out_ready) begin
            check_out();
            consumed = 1'b1;
        end
        cur = {x0_out, x1_out, y0_out, deltax_out, deltay_out, ystep_out, steep_out, point_out, err_out};
        if (out_valid && !out_ready) begin
            if (prev_stall) begin
                n_tests++;
                if (cur !== snap) begin
                    n_fail++;
                    $display("FAIL stall_hold: got %0h required %0h", cur, snap);
                end
            end
            snap       = cur;
            prev_stall = 1'b1;
        end else begin
            prev_stall = 1'b0;
        end
        if (in_valid && in_ready) begin
            q.push_back(idx);
            accepted = 1'b1;
        end
    endtask

    task automatic drain(input string nm);
        for (int c = 0; c < 30 && q.size() > 0; c++) step(1'b0, 0, 1'b1);
        chk(nm, 32'(q.size()), 32'd0);
        step(1'b0, 0, 1'b1);
    endtask

    initial begin
        int lat, sent, cyc, drop_size;

        //       x0    y0   x1   y1    ex0  ex1  ey0  dx    dy    ystep st pt
        set_vec(0,    0,   0,  10,   4,    0,  10,   0,   10,    4,  1, 0, 0);
        set_vec(1,    3,   2,   1,   9,    2,   9,   3,    7,    2, -1, 1, 0);
        set_vec(2, -512,   0, 511,   0, -512, 511,   0, 1023,    0, -1, 0, 0);
        set_vec(3,    5,   5,   5,   5,    5,   5,   5,    0,    0, -1, 0, 1);
        set_vec(4,   10,   4,   0,   0,    0,  10,   0,   10,    4,  1, 0, 0);
        set_vec(5,    0,   0,   3,  -3,    0,   3,   0,    3,    3, -1, 0, 0);
        set_vec(6,    2,  -5,   2,   7,   -5,   7,   2,   12,    0, -1, 1, 0);
        set_vec(7,  511,-512,-512, 511, -512, 511, 511, 1023, 1023, -1, 0, 0);
        set_vec(8,    1,   8,   4,   1,    1,   8,   4,    7,    3, -1, 1, 0);
        set_vec(9,   -3,  -1,  -1,   5,   -1,   5,  -3,    6,    2,  1, 1, 0);

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x0 = '0; x1 = '0; y0 = '0; y1 = '0;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_in_ready",  32'(in_ready),   32'd1);
        chk("rst_out_valid", 32'(out_valid),  32'd0);
        chk("rst_line_cnt",  32'(line_cnt),   32'd0);
        chk("rst_x0_out",    32'(x0_out),     32'd0);
        chk("rst_ystep",     32'(ystep_out),  32'd0);
        chk("rst_deltax",    32'(deltax_out), 32'd0);
        chk("rst_err",       32'(err_out),    32'd0);

        // Single-line latency
        step(1'b1, 0, 1'b1);
        lat = 0;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            step(1'b0, 0, 1'b1);
            if (consumed) lat = c;
        end
        chk("latency", 32'(lat), 32'd3);
        step(1'b0, 0, 1'b1);
        chk("cnt_after_one", 32'(line_cnt), 32'd1);

        // Back-to-back stream of every vector
        for (int i = 0; i < 10; i++) step(1'b1, i, 1'b1);
        drain("drain_stream");
        chk("cnt_after_stream", 32'(line_cnt), 32'd11);

        // Eight lines with a 5-cycle downstream stall
        @(negedge clk); rst = 1'b0; in_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        n_out = 0; sent = 0; cyc = 0; drop_size = -1;
        while ((sent < 8 || q.size() > 0) && cyc < 60) begin
            step(sent < 8, (sent < 8) ? sent : 0, !(cyc >= 4 && cyc <= 8));
            if (accepted) sent++;
            else if (sent < 8 && !in_ready && drop_size < 0) drop_size = q.size();
            cyc++;
        end
        chk("stall_held_lines", 32'(drop_size), 32'd3);
        chk("stall_all_sent",   32'(sent),      32'd8);
        chk("stall_delivered",  32'(n_out),     32'd8);
        step(1'b0, 0, 1'b1);
        chk("cnt_after_stall", 32'(line_cnt), 32'd8);

        // Nine more consumes: 17 total wraps a 4-bit counter to 1
        for (int k = 0; k < 9; k++) step(1'b1, k, 1'b1);
        drain("drain_wrap");
        chk("cnt_wrap", 32'(line_cnt), 32'd1);

        // Reset with two lines in flight
        step(1'b1, 2, 1'b1);
        step(1'b1, 3, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1; rst = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_line_cnt",  32'(line_cnt),  32'd0);
        rst = 1'b1;
        q.delete();
        n_seen = 0;
        repeat (10) step(1'b0, 0, 1'b1);
        chk("midrst_no_emerge", 32'(n_seen),   32'd0);
        chk("midrst_cnt_hold",  32'(line_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/line_setup_pipe.md
LINE_SETUP_PIPE -- requirements
Module: line_setup_pipe

Interface
REQ-001 Parameter WIDTH, default 10: signed two's-complement width of every endpoint coordinate.
REQ-002 Parameter CNT_W, default 16: width of the completed-line counter.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: reset, synchronous, active-low.
REQ-005 Port in_valid, input, 1: endpoint set on x0/x1/y0/y1 is valid.
REQ-006 Port in_ready, output, 1: block accepts the set this cycle.
REQ-007 Ports x0, x1, y0, y1, input, WIDTH each: signed line endpoints.
REQ-008 Port out_valid, output, 1: setup result valid.
REQ-009 Port out_ready, input, 1: downstream consumes the result this cycle.
REQ-010 Ports x0_out, x1_out, y0_out, output, WIDTH each: swapped start/end coordinates.
REQ-011 Ports deltax_out, deltay_out, output, WIDTH+1 each: unsigned deltas.
REQ-012 Port ystep_out, output, WIDTH: signed +1 or -1.
REQ-013 Port steep_out, output, 1: line steep (axes swapped).
REQ-014 Port point_out, output, 1: degenerate line, x0==x1 and y0==y1.
REQ-015 Port err_out, output, WIDTH+1: initial Bresenham error term.
REQ-016 Port line_cnt, output, CNT_W: count of results consumed.

Function
REQ-017 Transfer occurs on in_valid&&in_ready (accept) and on out_valid&&out_ready (consume).
REQ-018 Three register stages: S0 input capture; S1 dx=x1-x0, dy=y1-y0 in WIDTH+1 bits, abs values, steep=|dy|>|dx|; S2 swap and output; zero-stall latency from accept to out_valid is 3 cycles.
REQ-019 Each stage holds a valid bit and loads when empty or when its contents advance in the same cycle; bubbles collapse.
REQ-020 in_ready = !S0.valid || S0 advancing; combinational from out_ready; sustained throughput one line per cycle.
REQ-021 Ties (|dy|==|dx|) produce steep=0.
REQ-022 If steep, swap x and y of each endpoint; then if x0>x1 (signed), swap the endpoints.
REQ-023 deltax_out=x1-x0 and deltay_out=|y1-y0|, computed after swaps in WIDTH+1 bits, never overflowing for any legal input.
REQ-024 ystep_out=+1 if y0<y1 after swaps, else -1 (0x3FF at WIDTH=10), including y0==y1.
REQ-025 point_out=1 iff original x0==x1 and y0==y1; remaining outputs still follow REQ-021..024 (deltas 0, steep 0, ystep -1).
REQ-026 While out_valid && !out_ready, all output ports hold stable.
REQ-027 line_cnt increments by 1 on each consume and wraps from 2^CNT_W-1 to 0.
REQ-028 Accept and consume in the same cycle with a full pipeline: all stages advance, none dropped or duplicated.

Reset
REQ-029 When rst==0 at a clock edge, clear all stage valid bits and line_cnt; every data output resets to 0; out_valid=0; in_ready=1 from the first cycle after reset release.
REQ-030 Reset mid-operation discards all in-flight lines without producing a consume; no partial output follows.

Configuration
REQ-031 Macro LINE_SETUP_ERR_INIT_EN: when defined, err_out=deltax_out>>1 (arithmetic, floor), registered in S2 with the other outputs.
REQ-032 Without LINE_SETUP_ERR_INIT_EN, err_out is constant 0 and no error logic is synthesised; all other behaviour is identical.

Verification
REQ-033 Reset, then (0,0)->(10,4), out_ready=1: out_valid at cycle 3; x0=0, x1=10, y0=0, dx=10, dy=4, ystep=+1, steep=0, err=5 (macro on).
REQ-034 (3,2)->(1,9): steep=1; outputs x0=2, x1=9, y0=3, dx=7, dy=2, ystep=-1.
REQ-035 WIDTH=10, (-512,0)->(511,0): dx=1023 without overflow; dy=0; ystep=-1; point=0. Input (5,5)->(5,5): point=1.
REQ-036 Eight back-to-back lines, out_ready held 0 for 5 cycles mid-stream: in_ready deasserts after 3 held lines; outputs stable while stalled; all 8 delivered in order; line_cnt=8.
REQ-037 CNT_W=4, 17 consumed lines: line_cnt wraps to 1. Assert rst=0 with 2 lines in flight: out_valid=0 and line_cnt=0 next cycle; neither line emerges afterward.
